// File: rtl/output_tile_sched.sv
// Tile sequencer for the 4x4 threshold/address datapath: kicks one tile at a time,
// waits for calc_done, then streams the four 32-bit row words to SRAM over req/ack.
module output_tile_sched (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         start,
  input  logic [15:0]  pitch,
  input  logic [7:0]   tiles_x,
  input  logic [7:0]   tiles_y,
  input  logic         calc_done,
  input  logic [127:0] calc_data,
  input  logic [31:0]  calc_addr,
  input  logic         sram_ack,
  output logic         calc_en,
  output logic [31:0]  addr_calc_addr,
  output logic         sram_wen,
  output logic [31:0]  sram_waddr,
  output logic [31:0]  sram_wdata,
  output logic         busy,
  output logic         done
);

  typedef enum logic [2:0] {IDLE, KICK, RUN, WRITE, NEXT, FIN} state_t;

  state_t      state;
  logic [15:0] pitch_q;
  logic [7:0]  tx_q;
  logic [7:0]  ty_q;
  logic [7:0]  col;
  logic [7:0]  row;
  logic [31:0] row_base;
  logic [1:0]  k;

  logic [31:0] pitch_ext;
  logic [31:0] pitch4_ext;
  logic [31:0] row_base_nxt;
  logic [1:0]  k_nxt;
  logic        last_col;
  logic        last_row;

  always_comb begin
    pitch_ext    = {16'd0, pitch_q};
    pitch4_ext   = {14'd0, pitch_q, 2'b00};
    row_base_nxt = row_base + pitch4_ext;
    k_nxt        = k + 2'd1;
    last_col     = (col == tx_q - 8'd1);
    last_row     = (row == ty_q - 8'd1);
    // Enable drops the cycle done is seen so the datapath does not re-arm from IDLE.
    calc_en      = (state == KICK) || ((state == RUN) && !calc_done);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state          <= IDLE;
      pitch_q        <= '0;
      tx_q           <= '0;
      ty_q           <= '0;
      col            <= '0;
      row            <= '0;
      row_base       <= '0;
      k              <= '0;
      addr_calc_addr <= '0;
      sram_wen       <= 1'b0;
      sram_waddr     <= '0;
      sram_wdata     <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            pitch_q        <= pitch;
            tx_q           <= tiles_x;
            ty_q           <= tiles_y;
            col            <= '0;
            row            <= '0;
            row_base       <= '0;
            addr_calc_addr <= '0;
            busy           <= 1'b1;
            if ((tiles_x == 8'd0) || (tiles_y == 8'd0)) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state <= KICK;
            end
          end
        end
        KICK: state <= RUN;
        RUN: begin
          if (calc_done) begin
            k          <= '0;
            sram_waddr <= calc_addr;
            sram_wdata <= calc_data[31:0];
            sram_wen   <= 1'b1;
            state      <= WRITE;
          end
        end
        WRITE: begin
          if (sram_ack) begin
            if (k != 2'd3) begin
              k          <= k_nxt;
              sram_waddr <= sram_waddr + pitch_ext;
              sram_wdata <= calc_data[{k_nxt, 5'd0} +: 32];
            end else begin
              sram_wen <= 1'b0;
              state    <= NEXT;
            end
          end
        end
        NEXT: begin
          if (last_col && last_row) begin
            state <= FIN;
            done  <= 1'b1;
          end else if (!last_col) begin
            col            <= col + 8'd1;
            addr_calc_addr <= addr_calc_addr + 32'd4;
            state          <= KICK;
          end else begin
            col            <= '0;
            row            <= row + 8'd1;
            row_base       <= row_base_nxt;
            addr_calc_addr <= row_base_nxt;
            state          <= KICK;
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_output_tile_sched.sv
// Scoreboard bench for output_tile_sched with a fixed-latency datapath model.
module tb_output_tile_sched;

  logic         clk = 1'b0;
  logic         n_rst = 1'b1;
  logic         start = 1'b0;
  logic [15:0]  pitch = '0;
  logic [7:0]   tiles_x = '0;
  logic [7:0]   tiles_y = '0;
  logic         calc_done;
  logic [127:0] calc_data;
  logic [31:0]  calc_addr;
  logic         sram_ack = 1'b0;
  logic         calc_en;
  logic [31:0]  addr_calc_addr;
  logic         sram_wen;
  logic [31:0]  sram_waddr;
  logic [31:0]  sram_wdata;
  logic         busy;
  logic         done;

  int unsigned  n_checks = 0;
  int unsigned  n_pass = 0;
  logic [31:0]  sa = 32'h1000;
  int unsigned  exp_waddr[$];
  int unsigned  exp_off[$];
  logic [127:0] tile_data[$];
  logic [127:0] cur_data = '0;
  int unsigned  wr_k = 0;
  int unsigned  en_cnt = 0;
  int unsigned  done_cnt = 0;
  int           ack_mode = 0;
  int           stall_left = 0;
  logic         prev_stall = 1'b0;
  logic [64:0]  prev_out = '0;
  logic         dp_run;
  int           dp_cnt;

  always #5 clk = ~clk;

  output_tile_sched dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .start          (start),
    .pitch          (pitch),
    .tiles_x        (tiles_x),
    .tiles_y        (tiles_y),
    .calc_done      (calc_done),
    .calc_data      (calc_data),
    .calc_addr      (calc_addr),
    .sram_ack       (sram_ack),
    .calc_en        (calc_en),
    .addr_calc_addr (addr_calc_addr),
    .sram_wen       (sram_wen),
    .sram_waddr     (sram_waddr),
    .sram_wdata     (sram_wdata),
    .busy           (busy),
    .done           (done)
  );

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Datapath model: enable from idle clears done and starts; done flag set 19 cycles after the kick.
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      dp_run    <= 1'b0;
      dp_cnt    <= 0;
      calc_done <= 1'b0;
      calc_data <= '0;
      calc_addr <= '0;
    end else if (dp_run) begin
      if (dp_cnt == 1) begin
        dp_run    <= 1'b0;
        calc_done <= 1'b1;
      end
      dp_cnt <= dp_cnt - 1;
    end else if (calc_en) begin
      logic [127:0] d;
      d = {$urandom, $urandom, $urandom, $urandom};
      dp_run    <= 1'b1;
      dp_cnt    <= 18;
      calc_done <= 1'b0;
      calc_addr <= sa + 32'd1602 + addr_calc_addr;
      calc_data <= d;
      tile_data.push_back(d);
    end
  end

  always @(posedge clk) begin
    #1;
    case (ack_mode)
      0: sram_ack = 1'b1;
      1: sram_ack = ($urandom_range(0, 2) != 0);
      default: begin
        if (sram_wen && wr_k == 2 && stall_left > 0) begin
          sram_ack = 1'b0;
          stall_left--;
        end else begin
          sram_ack = 1'b1;
        end
      end
    endcase
  end

  always @(negedge clk) begin
    if (!n_rst) begin
      prev_stall = 1'b0;
    end else begin
      if (calc_en) en_cnt++;
      if (done) done_cnt++;
      if (calc_en && !dp_run) begin
        if (exp_off.size() == 0) chk("extra_tile", exp_off.size(), 1);
        else chk("addr_calc_addr", addr_calc_addr, exp_off.pop_front());
      end
      if (prev_stall) chk("stall_hold", {sram_wen, sram_waddr, sram_wdata}, prev_out);
      if (sram_wen && sram_ack) begin
        if (exp_waddr.size() == 0) chk("extra_write", exp_waddr.size(), 1);
        else chk("sram_waddr", sram_waddr, exp_waddr.pop_front());
        if (wr_k == 0) begin
          if (tile_data.size() == 0) begin
            chk("tile_data_avail", tile_data.size(), 1);
            cur_data = '0;
          end else begin
            cur_data = tile_data.pop_front();
          end
        end
        chk("sram_wdata", sram_wdata, cur_data[32*wr_k +: 32]);
        wr_k = (wr_k + 1) % 4;
      end
      prev_stall = sram_wen && !sram_ack;
      prev_out   = {sram_wen, sram_waddr, sram_wdata};
    end
  end

  task automatic clear_model();
    exp_waddr.delete();
    exp_off.delete();
    tile_data.delete();
    wr_k = 0;
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    start = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic push_frame(input logic [15:0] p, input logic [7:0] tx, input logic [7:0] ty);
    int unsigned p4 = 4 * int'(p);
    for (int r = 0; r < int'(ty); r++)
      for (int c = 0; c < int'(tx); c++) begin
        int unsigned off = r * p4 + c * 4;
        exp_off.push_back(off);
        for (int k = 0; k < 4; k++) exp_waddr.push_back(sa + 32'd1602 + off + k * int'(p));
      end
  endtask

  task automatic run_frame(input logic [15:0] p, input logic [7:0] tx, input logic [7:0] ty,
                           input bit chk_lat, input int extra_lat, input bit busy_start);
    int unsigned n = int'(tx) * int'(ty);
    int unsigned lat = 0;
    int unsigned budget = 200 * n + 20;
    bit got = 0;
    push_frame(p, tx, ty);
    @(posedge clk); #1;
    start = 1'b1; pitch = p; tiles_x = tx; tiles_y = ty;
    en_cnt = 0; done_cnt = 0;
    while (!got && lat < budget) begin
      @(posedge clk); #1;
      lat++;
      start = 1'b0;
      if (lat == 1) chk("busy_rise", busy, 1);
      if (busy_start && lat == 12) begin
        start = 1'b1; pitch = ~p; tiles_x = 8'd9; tiles_y = 8'd9;
      end
      if (done) got = 1;
    end
    if (!got) begin
      chk("done_seen", got, 1);
      do_reset();
      return;
    end
    if (chk_lat) begin
      if (n == 0) chk("zero_done_lat", lat <= 2, 1);
      else chk("done_lat", lat, 25 * n + 1 + extra_lat);
    end
    @(posedge clk); #1;
    chk("done_pulse_busy", {done, busy}, 2'b00);
    chk("done_count", done_cnt, 1);
    chk("calc_en_cycles", en_cnt, 19 * n);
    chk("writes_left", exp_waddr.size(), 0);
    chk("kicks_left", exp_off.size(), 0);
    chk("data_left", tile_data.size(), 0);
  endtask

  initial begin
    #2 n_rst = 1'b0;
    #3;
    chk("reset_outputs", {calc_en, addr_calc_addr, sram_wen, sram_waddr, sram_wdata, busy, done}, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;

    ack_mode = 0; sa = 32'h1000;
    run_frame(16'd64, 8'd1, 8'd1, 1, 0, 0);
    run_frame(16'd12, 8'd3, 8'd2, 1, 0, 0);

    ack_mode = 2; stall_left = 5; sa = 32'h2000;
    run_frame(16'd40, 8'd1, 8'd1, 1, 5, 0);

    ack_mode = 0;
    run_frame(16'd33, 8'd0, 8'd5, 1, 0, 0);
    run_frame(16'd33, 8'd3, 8'd0, 1, 0, 0);
    sa = 32'h0004_0000;
    run_frame(16'd100, 8'd2, 8'd2, 1, 0, 1);

    ack_mode = 1;
    for (int i = 0; i < 6; i++) begin
      logic [15:0] p;
      logic [7:0]  tx, ty;
      p  = 16'($urandom);
      tx = 8'($urandom_range(1, 4));
      ty = 8'($urandom_range(1, 3));
      sa = $urandom;
      run_frame(p, tx, ty, 0, 0, 0);
    end

    // Reset in the middle of a write burst.
    ack_mode = 0; sa = 32'h3000;
    begin
      int unsigned w = 0;
      push_frame(16'd20, 8'd2, 8'd1);
      @(posedge clk); #1;
      start = 1'b1; pitch = 16'd20; tiles_x = 8'd2; tiles_y = 8'd1;
      @(posedge clk); #1;
      start = 1'b0;
      while (!sram_wen && w < 60) begin
        @(posedge clk); #1;
        w++;
      end
      chk("reached_write", sram_wen, 1);
      @(posedge clk); #1;
      n_rst = 1'b0;
      #1;
      chk("async_reset_outputs",
          {calc_en, addr_calc_addr, sram_wen, sram_waddr, sram_wdata, busy, done}, '0);
      clear_model();
      done_cnt = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_rst = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("no_done_after_reset", done_cnt, 0);
      chk("idle_after_reset", {busy, calc_en, sram_wen}, 3'b000);
    end
    sa = 32'hFFFF_FF00;
    run_frame(16'hFFFF, 8'd2, 8'd2, 1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
